// File: rtl/maxpool_window_reader.sv
// maxpool_window_reader
// Holds one convolution result channel, written through the conv engine's
// write port. On start it walks the stored n_r x n_c matrix in
// non-overlapping 2x2 windows (stride 2, row-major) and streams the signed
// maximum of every window over a valid/ready handshake.
module maxpool_window_reader #(
    parameter int n_c                  = 26,
    parameter int n_r                  = 26,
    parameter int numWeightRstlConv    = 676,
    parameter int addressWidthRstlConv = 10,
    parameter int dataWidthRstlConv    = 8,
    parameter int idxWidth             = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wen,
    input  logic [addressWidthRstlConv-1:0]     wadd,
    input  logic signed [dataWidthRstlConv-1:0] data_in,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [dataWidthRstlConv-1:0] out_data,
    output logic [idxWidth-1:0]                 out_idx
);

    localparam int AW    = addressWidthRstlConv;
    localparam int DW    = dataWidthRstlConv;
    localparam int WIN_C = n_c / 2;
    localparam int WIN_R = n_r / 2;

    localparam logic [AW-1:0] LAST_WC  = AW'(WIN_C - 1);
    localparam logic [AW-1:0] LAST_WR  = AW'(WIN_R - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(2 * n_c);
    localparam logic [AW-1:0] COL_STEP = AW'(2);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(numWeightRstlConv);

    // Elaboration-time sanity checks on the geometry.
    if (n_r * n_c > numWeightRstlConv) begin : g_chk_depth
        $error("maxpool_window_reader: buffer depth smaller than n_r*n_c");
    end
    if (n_r * n_c > (2 ** addressWidthRstlConv)) begin : g_chk_addr
        $error("maxpool_window_reader: address width too small for n_r*n_c");
    end
    if (WIN_R * WIN_C > (2 ** idxWidth)) begin : g_chk_idx
        $error("maxpool_window_reader: idxWidth too small for window count");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [2:0]              k_reg;        // element sub-counter inside a window
    logic [AW-1:0]           wc_reg;       // window column
    logic [AW-1:0]           wr_reg;       // window row
    logic [AW-1:0]           row_base_reg; // 2*wr*n_c
    logic [AW-1:0]           col_off_reg;  // 2*wc
    logic [idxWidth-1:0]     idx_reg;      // linear window index
    logic signed [DW-1:0]    max_reg;
    logic signed [DW-1:0]    rdata_reg;
    logic signed [DW-1:0]    out_data_reg;
    logic [idxWidth-1:0]     out_idx_reg;

    logic signed [DW-1:0]    mem [0:numWeightRstlConv-1];

    logic [AW-1:0]           elem_off [4];
    logic [AW-1:0]           rd_addr;
    logic                    wr_ok;
    logic                    last_win;
    logic signed [DW-1:0]    max_cand;

    // Offsets of the four window elements relative to the window base:
    // 0, 1, n_c, n_c+1 (top-left, top-right, bottom-left, bottom-right).
    for (genvar gi = 0; gi < 4; gi++) begin : g_elem_off
        assign elem_off[gi] = AW'((gi / 2) * n_c + (gi % 2));
    end

    assign rd_addr  = row_base_reg + col_off_reg + elem_off[k_reg[1:0]];
    assign wr_ok    = wen && ({1'b0, wadd} < DEPTH) && !busy;
    assign last_win = (wc_reg == LAST_WC) && (wr_reg == LAST_WR);

    // First captured element seeds the running max; later ones compete (signed).
    assign max_cand = ((k_reg == 3'd1) || (rdata_reg > max_reg)) ? rdata_reg : max_reg;

    assign out_data = out_data_reg;
    assign out_idx  = out_idx_reg;

    // Result buffer: write port from the conv engine, registered read port for the scan.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wadd] <= data_in;
        end
        rdata_reg <= mem[rd_addr];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and status outputs, decoded from the current state.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RD;
                end
            end
            RD: begin
                busy = 1'b1;
                if (k_reg == 3'd4) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = last_win ? DONE : RD;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Window walk counters, running max and the held output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_reg        <= '0;
            wc_reg       <= '0;
            wr_reg       <= '0;
            row_base_reg <= '0;
            col_off_reg  <= '0;
            idx_reg      <= '0;
            max_reg      <= '0;
            out_data_reg <= '0;
            out_idx_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        k_reg        <= '0;
                        wc_reg       <= '0;
                        wr_reg       <= '0;
                        row_base_reg <= '0;
                        col_off_reg  <= '0;
                        idx_reg      <= '0;
                    end
                end
                RD: begin
                    // Address for element k goes out while element k-1 returns.
                    k_reg <= (k_reg == 3'd4) ? 3'd0 : k_reg + 3'd1;
                    if (k_reg != 3'd0) begin
                        max_reg <= max_cand;
                    end
                    if (k_reg == 3'd4) begin
                        out_data_reg <= max_cand;
                        out_idx_reg  <= idx_reg;
                    end
                end
                OUT: begin
                    // Output registers stay untouched until the handshake.
                    if (out_ready && !last_win) begin
                        k_reg   <= '0;
                        idx_reg <= idx_reg + 1'b1;
                        if (wc_reg == LAST_WC) begin
                            wc_reg       <= '0;
                            col_off_reg  <= '0;
                            wr_reg       <= wr_reg + 1'b1;
                            row_base_reg <= row_base_reg + ROW_STEP;
                        end else begin
                            wc_reg      <= wc_reg + 1'b1;
                            col_off_reg <= col_off_reg + COL_STEP;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_window_reader.sv
// Directed testbench for maxpool_window_reader (26x26 matrix, 169 windows).
module tb_maxpool_window_reader;

    logic              clk;
    logic              rst;
    logic              wen;
    logic [9:0]        wadd;
    logic signed [7:0] data_in;
    logic              start;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic [7:0]        out_idx;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference copy of what was written, and captured results of a pass.
    logic signed [7:0] model [0:675];
    logic signed [7:0] got_data [0:199];
    logic [7:0]        got_idx [0:199];
    int got_n, first_valid_cyc, done_cyc, busy_at_done, busy_after_start, done_after;

    maxpool_window_reader dut (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .wadd      (wadd),
        .data_in   (data_in),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [7:0] exp_max(input int w);
        int b;
        logic signed [7:0] m;
        b = 2 * (w / 13) * 26 + 2 * (w % 13);
        m = model[b];
        if (model[b + 1] > m) m = model[b + 1];
        if (model[b + 26] > m) m = model[b + 26];
        if (model[b + 27] > m) m = model[b + 27];
        return m;
    endfunction

    // kind 0: ramp i mod 100; kind 1: negative fill with two hand-built windows
    task automatic fill_mem(input int kind);
        logic signed [7:0] v;
        for (int i = 0; i < 676; i++) begin
            if (kind == 0) v = 8'(i % 100);
            else           v = 8'(-((i % 120) + 1));
            if (kind == 1) begin
                case (i)
                    0:  v = -8'sd5;
                    1:  v = -8'sd3;
                    26: v = -8'sd7;
                    27: v = -8'sd128;
                    2:  v = 8'sd127;
                    3:  v = -8'sd128;
                    28: v = 8'sd0;
                    29: v = 8'sd1;
                    default: ;
                endcase
            end
            @(negedge clk);
            wen = 1'b1; wadd = 10'(i); data_in = v;
            model[i] = v;
        end
        @(negedge clk);
        wen = 1'b0;
    endtask

    // Runs one pass with out_ready as currently set and records the stream.
    // mode 1: writes while busy; mode 2: start pulses in RD, OUT and DONE.
    task automatic run_pass(input int mode);
        got_n = 0; first_valid_cyc = -1; done_cyc = -1; busy_at_done = -1;
        for (int i = 0; i < 200; i++) begin
            got_data[i] = 'x; got_idx[i] = 'x;
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        busy_after_start = int'(busy);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc != 0) @(negedge clk);
            start = 1'b0; wen = 1'b0;
            if (mode == 1 && cyc < 4) begin
                wen = 1'b1; data_in = 8'sd127;
                case (cyc)
                    0: wadd = 10'd0;
                    1: wadd = 10'd1;
                    2: wadd = 10'd26;
                    default: wadd = 10'd27;
                endcase
            end
            if (mode == 2 && (cyc == 2 || cyc == 5 || cyc == 700)) start = 1'b1;
            if (done) begin
                done_cyc = cyc; busy_at_done = int'(busy);
                if (mode == 2) start = 1'b1;
                break;
            end
            if (out_valid && out_ready) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (got_n < 200) begin
                    got_data[got_n] = out_data; got_idx[got_n] = out_idx;
                end
                got_n++;
            end
        end
        @(negedge clk);
        start = 1'b0; wen = 1'b0;
        done_after = int'(done);
    endtask

    task automatic test_reset();
        rst = 1'b1; wen = 1'b0; wadd = '0; data_in = '0; start = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 8'sd0) $display("FAIL reset_data: got %0d want 0", out_data); else pass_cnt++;
        total_cnt++; if (out_idx !== 8'd0) $display("FAIL reset_idx: got %0d want 0", out_idx); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL post_reset_idle: busy %b valid %b want 0 0", busy, out_valid); else pass_cnt++;
        $display("reset: done");
    endtask

    task automatic test_ramp();
        fill_mem(0);
        out_ready = 1'b1;
        run_pass(0);
        total_cnt++; if (busy_after_start !== 1) $display("FAIL ramp_busy_start: got %0d want 1", busy_after_start); else pass_cnt++;
        total_cnt++; if (first_valid_cyc !== 5) $display("FAIL ramp_first_valid: got cycle %0d want 5", first_valid_cyc); else pass_cnt++;
        total_cnt++; if (got_data[0] !== 8'sd27) $display("FAIL ramp_win0: got %0d want 27", got_data[0]); else pass_cnt++;
        total_cnt++; if (got_idx[0] !== 8'd0) $display("FAIL ramp_idx0: got %0d want 0", got_idx[0]); else pass_cnt++;
        total_cnt++; if (got_data[1] !== 8'sd29) $display("FAIL ramp_win1: got %0d want 29", got_data[1]); else pass_cnt++;
        total_cnt++; if (got_n !== 169) $display("FAIL ramp_count: got %0d want 169", got_n); else pass_cnt++;
        total_cnt++; if (done_cyc !== 1014) $display("FAIL ramp_done_cycle: got %0d want 1014", done_cyc); else pass_cnt++;
        total_cnt++; if (busy_at_done !== 0) $display("FAIL ramp_busy_at_done: got %0d want 0", busy_at_done); else pass_cnt++;
        total_cnt++; if (done_after !== 0) $display("FAIL ramp_done_pulse: done still %0d a cycle later, want 0", done_after); else pass_cnt++;
        for (int i = 0; i < 169; i++) begin
            total_cnt++;
            if (got_data[i] !== exp_max(i) || got_idx[i] !== 8'(i))
                $display("FAIL ramp_window %0d: got data %0d idx %0d want data %0d idx %0d", i, got_data[i], got_idx[i], exp_max(i), i);
            else pass_cnt++;
        end
        $display("ramp: %0d windows, done at cycle %0d", got_n, done_cyc);
    endtask

    task automatic test_start_ignored();
        out_ready = 1'b1;
        run_pass(2);
        total_cnt++; if (got_n !== 169) $display("FAIL start_ign_count: got %0d want 169", got_n); else pass_cnt++;
        total_cnt++; if (done_cyc !== 1014) $display("FAIL start_ign_done_cycle: got %0d want 1014", done_cyc); else pass_cnt++;
        total_cnt++; if (got_data[1] !== 8'sd29 || got_idx[168] !== 8'd168) $display("FAIL start_ign_values: got %0d/%0d want 29/168", got_data[1], got_idx[168]); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL start_ign_after_done: busy %b want 0", busy); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL start_ign_idle: busy %b want 0", busy); else pass_cnt++;
        $display("start_ignored: %0d windows", got_n);
    endtask

    task automatic test_midpass_reset();
        bit found;
        found = 1'b0;
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (out_valid && out_idx == 8'd50) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total_cnt++; if (!found) $display("FAIL midrst_reach_win50: window 50 not seen within budget"); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 8'sd0) $display("FAIL midrst_data: got %0d want 0", out_data); else pass_cnt++;
        total_cnt++; if (out_idx !== 8'd0) $display("FAIL midrst_idx: got %0d want 0", out_idx); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL midrst_done: got %b want 0", done); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_no_autostart: busy %b want 0", busy); else pass_cnt++;
        run_pass(0);
        total_cnt++; if (got_data[0] !== 8'sd27 || got_idx[0] !== 8'd0) $display("FAIL midrst_rerun_win0: got %0d/%0d want 27/0", got_data[0], got_idx[0]); else pass_cnt++;
        total_cnt++; if (got_n !== 169) $display("FAIL midrst_rerun_count: got %0d want 169", got_n); else pass_cnt++;
        $display("midpass_reset: rerun %0d windows", got_n);
    endtask

    task automatic test_negative();
        fill_mem(1);
        out_ready = 1'b1;
        run_pass(0);
        total_cnt++; if (got_data[0] !== -8'sd3) $display("FAIL neg_win0: got %0d want -3", got_data[0]); else pass_cnt++;
        total_cnt++; if (got_data[1] !== 8'sd127) $display("FAIL neg_win1: got %0d want 127", got_data[1]); else pass_cnt++;
        total_cnt++; if (got_n !== 169) $display("FAIL neg_count: got %0d want 169", got_n); else pass_cnt++;
        for (int i = 0; i < 169; i++) begin
            total_cnt++;
            if (got_data[i] !== exp_max(i))
                $display("FAIL neg_window %0d: got %0d want %0d", i, got_data[i], exp_max(i));
            else pass_cnt++;
        end
        $display("negative: win0 %0d win1 %0d", got_data[0], got_data[1]);
    endtask

    task automatic test_backpressure();
        bit found;
        logic signed [7:0] hold_data;
        logic [7:0] hold_idx;
        found = 1'b0;
        out_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total_cnt++; if (!found) $display("FAIL bp_first_valid: out_valid never rose"); else pass_cnt++;
        hold_data = out_data; hold_idx = out_idx;
        total_cnt++; if (hold_data !== -8'sd3 || hold_idx !== 8'd0) $display("FAIL bp_win0: got %0d/%0d want -3/0", hold_data, hold_idx); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b1 || out_data !== -8'sd3 || out_idx !== 8'd0)
                $display("FAIL bp_hold cycle %0d: valid %b data %0d idx %0d want 1 -3 0", i, out_valid, out_data, out_idx);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_after_handshake: valid %b want 0", out_valid); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_rd_low %0d: valid %b want 0", i, out_valid); else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'sd127 || out_idx !== 8'd1)
            $display("FAIL bp_win1: valid %b data %0d idx %0d want 1 127 1", out_valid, out_data, out_idx);
        else pass_cnt++;
        out_ready = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        total_cnt++; if (!found) $display("FAIL bp_finish: done not seen within budget"); else pass_cnt++;
        @(negedge clk);
        $display("backpressure: held window 0 for 10 cycles");
    endtask

    task automatic test_dropped_writes();
        out_ready = 1'b1;
        run_pass(1);
        total_cnt++; if (got_data[0] !== -8'sd3) $display("FAIL drop_busy_win0: got %0d want -3", got_data[0]); else pass_cnt++;
        total_cnt++; if (got_n !== 169) $display("FAIL drop_busy_count: got %0d want 169", got_n); else pass_cnt++;
        @(negedge clk);
        wen = 1'b1; wadd = 10'd700; data_in = 8'sd99;
        @(negedge clk);
        wen = 1'b0;
        run_pass(0);
        total_cnt++; if (got_data[0] !== -8'sd3 || got_data[1] !== 8'sd127) $display("FAIL drop_rerun_win01: got %0d/%0d want -3/127", got_data[0], got_data[1]); else pass_cnt++;
        for (int i = 0; i < 169; i++) begin
            total_cnt++;
            if (got_data[i] !== exp_max(i) || got_idx[i] !== 8'(i))
                $display("FAIL drop_window %0d: got %0d idx %0d want %0d idx %0d", i, got_data[i], got_idx[i], exp_max(i), i);
            else pass_cnt++;
        end
        $display("dropped_writes: second pass %0d windows", got_n);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_start_ignored();
        test_midpass_reset();
        test_negative();
        test_backpressure();
        test_dropped_writes();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
